load_writeback_unit: RTL and testbench
======================================

# load_writeback_unit

Write-side initiator for the 32 x 64-bit general-purpose register file. Accepts completed load results (opcode, destination register, raw 64-bit memory data) from the load/store path, formats them by load width (zero-extend or sign-extend), and buffers them in a small FIFO. It then issues them one at a time to the register file write port over a valid/ready handshake. It also exports a per-register pending mask so the read side can stall on read-after-write hazards.

## Interface
- DEPTH, 4, FIFO entries (power of two, 2..16)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  load result offered
- in_ready  out  1  unit can accept (FIFO not full)
- in_opcode  in  6  load opcode selecting width/extension
- in_rd  in  5  destination register
- in_data  in  64  raw load data, right-aligned
- wb_valid  out  1  register write request
- wb_ready  in  1  register file accepts write this cycle
- wb_addr  out  5  register to write
- wb_data  out  64  formatted write data
- pending  out  32  bit r set while any buffered or in-flight write targets register r
- err_opcode  out  1  one-cycle pulse: unsupported opcode dropped
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage

## Operation
- Formatting is applied at enqueue; FIFO stores {rd, data64}:
  - 34 lbz: {56'b0, d[7:0]}
  - 40 lhz: {48'b0, d[15:0]}
  - 42 lha: {{48{d[15]}}, d[15:0]} (sign-extend halfword)
  - 32 lwz: {32'b0, d[31:0]}
  - 48 ld: d[63:0]
  - Any other opcode: handshake completes, nothing enqueued, err_opcode pulses the next cycle.
- Output stage states:
  - EMPTY: wb_valid=0. Loads from the FIFO head when count>0, or directly from input when the FIFO is empty (bypass still takes one register stage).
  - HOLD: wb_valid=1. wb_addr/wb_data stay stable until wb_ready. On wb_valid&&wb_ready, the next entry is loaded the same edge if available (stays HOLD); otherwise the stage goes to EMPTY.
- Ordering is strictly FIFO. Multiple entries to the same rd are all written, in order; the last one wins in the register file.
- pending is recomputed combinationally as the OR of one-hot(rd) over all valid FIFO entries plus the output stage when HOLD. A bit clears in the cycle after its final write handshake.
- r0 is an ordinary register and is written normally.

## Timing
- Reset (rst_n=0 at clk edge):
  - Outputs: wb_valid=0, wb_addr=0, wb_data=0, err_opcode=0, count=0, pending=0, in_ready=1 from the first cycle after reset.
  - FIFO pointers clear.
  - Reset mid-operation discards all buffered and held writes with no partial write.
- in_ready = (count != DEPTH). An accept is never allowed when full, even if a pop happens the same cycle.
- Latency: a load accepted at edge N into an empty unit gives wb_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one write per cycle with wb_ready held high. Simultaneous enqueue and dequeue leave count unchanged.
- Total buffering is DEPTH+1 (FIFO plus output stage).
- Pointer wrap-around is modulo DEPTH and is invisible externally.
- wb_ready while wb_valid=0 is ignored.

## Test plan
- Format check: with wb_ready=1, offer in_data=64'hFFFF_FFFF_FFFF_8081 with opcodes 34, 40, 42, 32, 48 to rd=1..5 -> wb_data sequence 64'h81, 64'h8081, 64'hFFFF_FFFF_FFFF_8081, 64'hFFFF_8081, 64'hFFFF_FFFF_FFFF_8081, each one cycle after accept, back-to-back.
- Backpressure/full: wb_ready=0, offer 6 loads with DEPTH=4 -> 5 accepted (1 held + 4 queued), in_ready=0, count=4, wb_addr/wb_data stable. Release wb_ready -> 5 writes in order, in_ready returns to 1 the cycle after the first pop.
- Pending: enqueue rd=7 twice and rd=9 once under wb_ready=0 -> pending=32'h0000_0280. Bit 7 clears only after the second rd=7 write; bit 9 clears after its write.
- Illegal opcode: in_opcode=6'd63, in_rd=3 -> accepted, err_opcode=1 for exactly one cycle, no wb_valid, pending[3] never set.
- Simultaneous push/pop at count=2 with wb_ready=1 -> count stays 2 across 10 cycles, one write per cycle, order preserved through pointer wrap.
- Reset mid-operation: 3 entries queued and HOLD active, pulse rst_n=0 for one edge -> next cycle wb_valid=0, pending=0, count=0, in_ready=1, no stale write emitted afterwards.

Source files
------------

// File: rtl/load_writeback_unit_if.sv
// Bundle between the load/store path, the register-file write port and the
// load writeback unit. The master modport is the unit's own view.
interface load_writeback_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [63:0]   in_data;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_addr;
  logic [63:0]   wb_data;
  logic [31:0]   pending;
  logic          err_opcode;
  logic [CW-1:0] count;

  modport master (
    input  in_valid, in_opcode, in_rd, in_data, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, pending, err_opcode, count
  );

  modport slave (
    output in_valid, in_opcode, in_rd, in_data, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, pending, err_opcode, count
  );
endinterface

// File: rtl/load_writeback_unit.sv
// Formats completed loads by width, queues them and writes them to the
// register file one at a time, exporting a per-register pending mask.
module load_writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  load_writeback_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {EMPTY, HOLD} stage_t;

  stage_t        state;
  logic [4:0]    fifo_rd   [DEPTH];
  logic [63:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [4:0]    out_addr;
  logic [63:0]   out_data;
  logic          err_q;

  logic          legal;
  logic [63:0]   fmt_data;
  logic          accept;
  logic          stage_free;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [31:0]   pend;
  logic [PW-1:0] off;

  always_comb begin
    legal    = 1'b1;
    fmt_data = bus.in_data;
    case (bus.in_opcode)
      6'd34:   fmt_data = {56'b0, bus.in_data[7:0]};
      6'd40:   fmt_data = {48'b0, bus.in_data[15:0]};
      6'd42:   fmt_data = {{48{bus.in_data[15]}}, bus.in_data[15:0]};
      6'd32:   fmt_data = {32'b0, bus.in_data[31:0]};
      6'd48:   fmt_data = bus.in_data;
      default: legal    = 1'b0;
    endcase
  end

  // An empty FIFO lets a new load go straight into the output stage.
  assign bus.in_ready = (cnt != CW'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign stage_free   = (state == EMPTY) || bus.wb_ready;
  assign pop          = stage_free && (cnt != '0);
  assign bypass       = stage_free && (cnt == '0) && accept && legal;
  assign push         = accept && legal && !bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.in_rd;
      fifo_data[wr_ptr] <= fmt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_addr <= '0;
      out_data <= '0;
      err_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      err_q <= accept && !legal;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (pop) begin
        state    <= HOLD;
        out_addr <= fifo_rd[rd_ptr];
        out_data <= fifo_data[rd_ptr];
      end else if (bypass) begin
        state    <= HOLD;
        out_addr <= bus.in_rd;
        out_data <= fmt_data;
      end else if (stage_free) begin
        state    <= EMPTY;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < cnt) pend[fifo_rd[i]] = 1'b1;
    end
    if (state == HOLD) pend[out_addr] = 1'b1;
  end

  assign bus.wb_valid   = (state == HOLD);
  assign bus.wb_addr    = out_addr;
  assign bus.wb_data    = out_data;
  assign bus.pending    = pend;
  assign bus.err_opcode = err_q;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_load_writeback_unit.sv
// Scoreboard bench: a queue of outstanding writes models FIFO plus output stage,
// and a negedge monitor compares every DUT output against it each cycle.
module tb_load_writeback_unit;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  load_writeback_unit_if #(.DEPTH(DEPTH)) bus ();

  load_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  wr_t         expQ[$];
  logic        expErr      = 1'b0;
  logic        nextErr;
  bit          modelLive   = 1'b0;
  int          occ;
  bit          modelReady;
  logic [31:0] expPend;
  wr_t         item;

  function automatic bit isLegal(input logic [5:0] op);
    return (op == 6'd34) || (op == 6'd40) || (op == 6'd42) || (op == 6'd32) || (op == 6'd48);
  endfunction

  function automatic logic [63:0] fmtModel(input logic [5:0] op, input logic [63:0] d);
    logic [63:0] h;
    case (op)
      6'd34:   return d % 64'd256;
      6'd40:   return d % 64'd65536;
      6'd42: begin
        h = d % 64'd65536;
        return (h >= 64'd32768) ? (h + 64'hFFFF_FFFF_FFFF_0000) : h;
      end
      6'd32:   return d % 64'h1_0000_0000;
      default: return d;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare first, then advance the model by what the coming rising edge will do.
  always @(negedge clk) begin
    occ        = (expQ.size() > 0) ? expQ.size() - 1 : 0;
    modelReady = (occ != DEPTH);
    if (modelLive) begin
      expPend = '0;
      for (int k = 0; k < expQ.size(); k++) expPend = expPend | (32'd1 << expQ[k].rd);
      checkOutput("wb_valid", 64'(bus.wb_valid), 64'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("wb_addr", 64'(bus.wb_addr), 64'(expQ[0].rd));
        checkOutput("wb_data", bus.wb_data, expQ[0].data);
      end
      checkOutput("count", 64'(bus.count), 64'(occ));
      checkOutput("in_ready", 64'(bus.in_ready), 64'(modelReady));
      checkOutput("pending", 64'(bus.pending), 64'(expPend));
      checkOutput("err_opcode", 64'(bus.err_opcode), 64'(expErr));
    end
    if (!rst_n) begin
      expQ.delete();
      expErr    = 1'b0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      nextErr = 1'b0;
      if (expQ.size() != 0 && bus.wb_ready) void'(expQ.pop_front());
      if (bus.in_valid && modelReady) begin
        if (isLegal(bus.in_opcode)) begin
          item.rd   = bus.in_rd;
          item.data = fmtModel(bus.in_opcode, bus.in_data);
          expQ.push_back(item);
        end else begin
          nextErr = 1'b1;
        end
      end
      expErr = nextErr;
    end
  end

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [4:0] rd,
                               input logic [63:0] d, input logic rdy);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_data   = d;
    bus.wb_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'd0, 5'd0, 64'd0, rdy);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  logic [5:0] fmtOps [5] = '{6'd34, 6'd40, 6'd42, 6'd32, 6'd48};

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_data   = '0;
    bus.wb_ready  = 1'b0;
    @(posedge clk);
    #1;
    idle(1, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Width formatting, back-to-back
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, fmtOps[i], 5'(i + 1), 64'hFFFF_FFFF_FFFF_8081, 1'b1);
    idle(3, 1'b1);

    // Backpressure until full, then drain
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 6'd48, 5'(10 + i), rnd64(), 1'b0);
    idle(3, 1'b0);
    idle(8, 1'b1);

    // Pending mask with a repeated destination
    applyStimulus(1'b1, 6'd32, 5'd7, rnd64(), 1'b0);
    applyStimulus(1'b1, 6'd32, 5'd7, rnd64(), 1'b0);
    applyStimulus(1'b1, 6'd34, 5'd9, rnd64(), 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Unsupported opcode
    applyStimulus(1'b1, 6'd63, 5'd3, rnd64(), 1'b1);
    idle(3, 1'b1);

    // Steady push/pop at count 2 across pointer wrap
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 6'd48, 5'(20 + i), rnd64(), 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, fmtOps[i % 5], 5'(i), rnd64(), 1'b1);
    idle(5, 1'b1);

    // Reset with HOLD active and three entries queued
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 6'd42, 5'(4 + i), rnd64(), 1'b0);
    rst_n = 1'b0;
    idle(1, 1'b0);
    rst_n = 1'b1;
    idle(5, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) < 8) ? fmtOps[$urandom_range(0, 4)] : 6'($urandom_range(0, 63)),
                    5'($urandom_range(0, 31)),
                    rnd64(),
                    ($urandom_range(0, 9) < 7));
    end
    idle(10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
